// File: rtl/dma_timing_priority_ctrl.sv
// Purpose : 8237-style DMA timing/priority control for 4 channels (SI/S0..S4 sequencer, HRQ/HLDA handshake, strobes).
// Latency : DREQ at edge k -> HRQ after k; with HLDA high S1 after k+1, DACK after k+2, updateAddrCnt after k+4.
// Backpr. : waits in S0 until HLDA; HLDA loss in S1..S4 aborts to SI; demand mode pauses when DREQ drops.
//
// Ports:
//   CLK, RESET          clock, synchronous active-high reset
//   DREQ, maskReg       per-channel request and mask
//   HLDA, CS_N, EOP_N   hold acknowledge, chip select, external end-of-process
//   ctrlDisable         blocks all new services
//   rotatingPriority    0 fixed (ch0 highest), 1 rotating
//   chMode, xferType    per-channel 2-bit mode and transfer type
//   tcIn                active channel word count is zero
//   HRQ/AEN/ADSTB       bus handshake and address strobes
//   DACK, activeCh      one-hot acknowledge and latched channel
//   programCondition    CPU may access registers
//   loadAddr, updateAddrCnt, tcPulse  datapath controls
//   MEMR_N/MEMW_N/IOR_OUT_N/IOW_OUT_N active-low transfer strobes
module dma_timing_priority_ctrl #(
  parameter int NUM_CH = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [NUM_CH-1:0]     DREQ,
  input  logic                  HLDA,
  input  logic                  CS_N,
  input  logic                  EOP_N,
  input  logic [NUM_CH-1:0]     maskReg,
  input  logic                  ctrlDisable,
  input  logic                  rotatingPriority,
  input  logic [2*NUM_CH-1:0]   chMode,
  input  logic [2*NUM_CH-1:0]   xferType,
  input  logic                  tcIn,
  output logic                  HRQ,
  output logic                  AEN,
  output logic                  ADSTB,
  output logic [NUM_CH-1:0]     DACK,
  output logic [1:0]            activeCh,
  output logic                  programCondition,
  output logic                  loadAddr,
  output logic                  updateAddrCnt,
  output logic [NUM_CH-1:0]     tcPulse,
  output logic                  MEMR_N,
  output logic                  MEMW_N,
  output logic                  IOR_OUT_N,
  output logic                  IOW_OUT_N
);

  typedef enum logic [2:0] {ST_SI, ST_S0, ST_S1, ST_S2, ST_S3, ST_S4} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_active_ch;
  logic [1:0]  r_prio;       // channel currently holding highest priority
  logic [1:0]  r_mode;       // mode/type latched at grant so strobes never see live inputs
  logic [1:0]  r_xfer;
  logic        r_tc_pend;    // TC/EOP seen in S4: pulse status for one cycle in SI

  logic [NUM_CH-1:0] w_valid_req;
  logic [NUM_CH-1:0] w_onehot;
  logic [1:0]        w_base;
  logic [1:0]        w_winner;
  logic              w_found;
  logic              w_any_req;
  logic              w_grant;
  logic              w_svc_end;
  logic              w_tc_end;

  assign w_valid_req = DREQ & ~maskReg & {NUM_CH{~ctrlDisable}};
  assign w_any_req   = |w_valid_req;
  assign w_onehot    = {{(NUM_CH-1){1'b0}}, 1'b1} << r_active_ch;
  assign w_tc_end    = tcIn | ~EOP_N;

  // Scan from the highest-priority channel upward, wrapping modulo 4.
  always_comb begin
    w_base   = rotatingPriority ? r_prio : 2'd0;
    w_winner = w_base;
    w_found  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!w_found && w_valid_req[w_base + 2'(i)]) begin
        w_winner = w_base + 2'(i);
        w_found  = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_SI: if (w_any_req) w_state_nxt = ST_S0;
      ST_S0: begin
        if (!w_any_req)  w_state_nxt = ST_SI;
        else if (HLDA)   w_state_nxt = ST_S1;
      end
      ST_S1: w_state_nxt = HLDA ? ST_S2 : ST_SI;
      ST_S2: w_state_nxt = HLDA ? ST_S3 : ST_SI;
      ST_S3: w_state_nxt = HLDA ? ST_S4 : ST_SI;
      ST_S4: begin
        if (!HLDA || w_tc_end) begin
          w_state_nxt = ST_SI;
        end else begin
          case (r_mode)
            2'b00:   w_state_nxt = w_valid_req[r_active_ch] ? ST_S1 : ST_SI;
            2'b10:   w_state_nxt = ST_S1;
            default: w_state_nxt = ST_SI;
          endcase
        end
      end
      default: w_state_nxt = ST_SI;
    endcase
  end

  assign w_grant   = (r_state == ST_S0) && w_any_req && HLDA;
  // Only a completed service (not an HLDA abort) moves the priority pointer.
  assign w_svc_end = (r_state == ST_S4) && HLDA && (w_state_nxt == ST_SI);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= ST_SI;
      r_active_ch <= 2'd0;
      r_prio      <= 2'd0;
      r_mode      <= 2'd0;
      r_xfer      <= 2'd0;
      r_tc_pend   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tc_pend <= (r_state == ST_S4) && HLDA && w_tc_end;
      if (w_grant) begin
        r_active_ch <= w_winner;
        r_mode      <= chMode[{w_winner, 1'b0} +: 2];
        r_xfer      <= xferType[{w_winner, 1'b0} +: 2];
      end
      if (w_svc_end && rotatingPriority) r_prio <= r_active_ch + 2'd1;
    end
  end

  always_comb begin
    HRQ           = 1'b0;
    AEN           = 1'b0;
    ADSTB         = 1'b0;
    loadAddr      = 1'b0;
    updateAddrCnt = 1'b0;
    DACK          = '0;
    MEMR_N        = 1'b1;
    MEMW_N        = 1'b1;
    IOR_OUT_N     = 1'b1;
    IOW_OUT_N     = 1'b1;
    case (r_state)
      ST_S0: HRQ = 1'b1;
      ST_S1: begin
        HRQ      = 1'b1;
        AEN      = 1'b1;
        ADSTB    = 1'b1;
        loadAddr = 1'b1;
      end
      ST_S2, ST_S3: begin
        HRQ  = 1'b1;
        AEN  = 1'b1;
        DACK = w_onehot;
        // read = memory to I/O, write = I/O to memory; second strobe joins in S3
        if (r_xfer == 2'b10) begin
          MEMR_N    = 1'b0;
          IOW_OUT_N = (r_state == ST_S3) ? 1'b0 : 1'b1;
        end else if (r_xfer == 2'b01) begin
          IOR_OUT_N = 1'b0;
          MEMW_N    = (r_state == ST_S3) ? 1'b0 : 1'b1;
        end
      end
      ST_S4: begin
        HRQ           = 1'b1;
        AEN           = 1'b1;
        DACK          = w_onehot;
        updateAddrCnt = 1'b1;
      end
      default: ;
    endcase
  end

  assign tcPulse          = r_tc_pend ? w_onehot : '0;
  assign activeCh         = r_active_ch;
  assign programCondition = (r_state == ST_SI) && !CS_N && !HLDA;

endmodule

// File: tb/tb_dma_timing_priority_ctrl.sv
// Directed bench for dma_timing_priority_ctrl: reset/idle, fixed and rotating
// priority, demand with TC, HLDA abort, block with EOP, S0 abandon, mid-transfer reset.
module tb_dma_timing_priority_ctrl;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] DREQ;
  logic       HLDA;
  logic       CS_N;
  logic       EOP_N;
  logic [3:0] maskReg;
  logic       ctrlDisable;
  logic       rotatingPriority;
  logic [7:0] chMode;
  logic [7:0] xferType;
  logic       tcIn;
  logic       HRQ, AEN, ADSTB, programCondition, loadAddr, updateAddrCnt;
  logic [3:0] DACK, tcPulse;
  logic [1:0] activeCh;
  logic       MEMR_N, MEMW_N, IOR_OUT_N, IOW_OUT_N;

  int errors = 0;
  int checks = 0;

  dma_timing_priority_ctrl #(.NUM_CH(4)) dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .HLDA(HLDA), .CS_N(CS_N), .EOP_N(EOP_N),
    .maskReg(maskReg), .ctrlDisable(ctrlDisable), .rotatingPriority(rotatingPriority),
    .chMode(chMode), .xferType(xferType), .tcIn(tcIn),
    .HRQ(HRQ), .AEN(AEN), .ADSTB(ADSTB), .DACK(DACK), .activeCh(activeCh),
    .programCondition(programCondition), .loadAddr(loadAddr), .updateAddrCnt(updateAddrCnt),
    .tcPulse(tcPulse), .MEMR_N(MEMR_N), .MEMW_N(MEMW_N), .IOR_OUT_N(IOR_OUT_N), .IOW_OUT_N(IOW_OUT_N)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bundle order: HRQ AEN ADSTB loadAddr updateAddrCnt DACK[3:0] tcPulse[3:0] {MEMR_N MEMW_N IOR_OUT_N IOW_OUT_N}
  task automatic chk_out(input string tag, input logic hrq, input logic aen, input logic adstb,
                         input logic ld, input logic upd, input logic [3:0] dack,
                         input logic [3:0] tcp, input logic [3:0] strb);
    logic [16:0] obs;
    logic [16:0] exp;
    obs = {HRQ, AEN, ADSTB, loadAddr, updateAddrCnt, DACK, tcPulse, MEMR_N, MEMW_N, IOR_OUT_N, IOW_OUT_N};
    exp = {hrq, aen, adstb, ld, upd, dack, tcp, strb};
    chk(tag, 32'(obs), 32'(exp));
  endtask

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    RESET = 1'b1; DREQ = 4'b1111; HLDA = 1'b0; CS_N = 1'b1; EOP_N = 1'b1;
    maskReg = 4'b0000; ctrlDisable = 1'b0; rotatingPriority = 1'b0;
    chMode = 8'b01_01_01_01; xferType = 8'b00_00_00_00; tcIn = 1'b0;

    // Reset / idle
    tick();
    chk_out("reset1", 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hF);
    tick();
    chk_out("reset2", 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hF);
    chk("reset_ch", 32'(activeCh), 0);
    RESET = 1'b0; CS_N = 1'b0;
    #1;
    chk("prog_cond", 32'(programCondition), 1);
    tick();
    chk_out("hrq_rise", 1, 0, 0, 0, 0, 4'h0, 4'h0, 4'hF);
    chk("prog_cond_s0", 32'(programCondition), 0);
    // S0 abandon: request withdrawn while HLDA low
    DREQ = 4'b0000;
    tick();
    chk_out("s0_abandon", 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hF);

    // Fixed priority single read on ch1, ch3 starves
    CS_N = 1'b1; HLDA = 1'b1; DREQ = 4'b1010; xferType = 8'b00_00_10_00;
    for (int pass = 0; pass < 2; pass++) begin
      tick();
      chk_out("fx_s0", 1, 0, 0, 0, 0, 4'h0, 4'h0, 4'hF);
      tick();
      chk_out("fx_s1", 1, 1, 1, 1, 0, 4'h0, 4'h0, 4'hF);
      chk("fx_ch", 32'(activeCh), 1);
      tick();
      chk_out("fx_s2", 1, 1, 0, 0, 0, 4'b0010, 4'h0, 4'b0111);
      tick();
      chk_out("fx_s3", 1, 1, 0, 0, 0, 4'b0010, 4'h0, 4'b0110);
      tick();
      chk_out("fx_s4", 1, 1, 0, 0, 1, 4'b0010, 4'h0, 4'hF);
      if (pass == 1) DREQ = 4'b0000;
      tick();
      chk_out("fx_si", 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hF);
    end

    // Rotating priority, all single verify
    rotatingPriority = 1'b1; DREQ = 4'b1111; xferType = 8'h00;
    for (int s = 0; s < 5; s++) begin
      tick();
      tick();
      tick();
      chk("rot_dack", 32'(DACK), 32'(4'b0001 << order[s]));
      tick();
      tick();
      if (s == 4) DREQ = 4'b0000;
      tick();
    end
    chk_out("rot_idle", 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hF);

    // HLDA abort: pointer is at ch1, must still be ch1 after the abort
    DREQ = 4'b1111;
    tick();
    tick();
    chk("ab_ch", 32'(activeCh), 1);
    tick();
    chk("ab_dack", 32'(DACK), 32'(4'b0010));
    HLDA = 1'b0;
    tick();
    chk_out("ab_si", 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hF);
    HLDA = 1'b1;
    tick();
    tick();
    chk("ab_regrant", 32'(activeCh), 1);
    tick();
    tick();
    tick();
    chk_out("ab_s4", 1, 1, 0, 0, 1, 4'b0010, 4'h0, 4'hF);
    DREQ = 4'b0000;
    tick();

    // Demand write on ch2 with TC on the third S4
    rotatingPriority = 1'b0; DREQ = 4'b0100;
    chMode = 8'b01_00_01_01; xferType = 8'b00_01_00_00;
    tick();
    tick();
    chk("dm_ch", 32'(activeCh), 2);
    for (int i = 0; i < 3; i++) begin
      chk_out("dm_s1", 1, 1, 1, 1, 0, 4'h0, 4'h0, 4'hF);
      tick();
      chk_out("dm_s2", 1, 1, 0, 0, 0, 4'b0100, 4'h0, 4'b1101);
      tick();
      chk_out("dm_s3", 1, 1, 0, 0, 0, 4'b0100, 4'h0, 4'b1001);
      tick();
      chk_out("dm_s4", 1, 1, 0, 0, 1, 4'b0100, 4'h0, 4'hF);
      if (i == 2) tcIn = 1'b1;
      tick();
    end
    chk_out("dm_tc", 0, 0, 0, 0, 0, 4'h0, 4'b0100, 4'hF);
    tcIn = 1'b0; DREQ = 4'b0000;
    tick();
    chk_out("dm_tc_clr", 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hF);

    // Block verify on ch3: continues with DREQ gone, ends on EOP
    chMode = 8'b10_00_01_01; xferType = 8'h00; DREQ = 4'b1000;
    tick();
    tick();
    chk("bk_ch", 32'(activeCh), 3);
    tick();
    chk_out("bk_s2", 1, 1, 0, 0, 0, 4'b1000, 4'h0, 4'hF);
    tick();
    tick();
    DREQ = 4'b0000;
    tick();
    chk_out("bk_s1", 1, 1, 1, 1, 0, 4'h0, 4'h0, 4'hF);
    tick();
    tick();
    tick();
    EOP_N = 1'b0;
    tick();
    chk_out("bk_eop", 0, 0, 0, 0, 0, 4'h0, 4'b1000, 4'hF);
    EOP_N = 1'b1;
    tick();
    chk_out("bk_idle", 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hF);

    // Reset mid-transfer
    chMode = 8'b01_01_01_01; xferType = 8'b00_00_00_10; DREQ = 4'b0001;
    tick();
    tick();
    tick();
    tick();
    chk_out("mr_s3", 1, 1, 0, 0, 0, 4'b0001, 4'h0, 4'b0110);
    RESET = 1'b1;
    tick();
    chk_out("mr_reset", 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'hF);
    RESET = 1'b0; DREQ = 4'b0000;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
